// File: rtl/imem_dmem_arbiter_if.sv
// Request/response bus used for the fetch port, the data port and the memory side of the arbiter.
// The requester drives the master modport; the responder drives the slave modport.
interface imem_dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
);
    logic                  req;
    logic                  we;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wstrb;
    logic                  ack;
    logic [DATA_W-1:0]     rdata;

    modport master (output req, we, addr, wdata, wstrb, input ack, rdata);
    modport slave  (input req, we, addr, wdata, wstrb, output ack, rdata);
endinterface

// File: rtl/imem_dmem_arbiter.sv
// Serialises instruction-fetch and data-memory accesses onto one single-ported memory.
// DM has priority; IF is forced through after STARVE_LIMIT consecutive DM grants while it waits.
module imem_dmem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 64,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clock,
    input  logic                reset,
    imem_dmem_arbiter_if.slave  if_bus,
    imem_dmem_arbiter_if.slave  dm_bus,
    imem_dmem_arbiter_if.master m_bus,
    output logic                stall_if,
    output logic                stall_mem,
    output logic                busy,
    output logic                owner
);
    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    state_e              state;
    state_e              state_nxt;
    logic [CNT_W-1:0]    starve_cnt;
    logic [ADDR_W-1:0]   m_addr;
    logic                m_we;
    logic [DATA_W-1:0]   m_wdata;
    logic [STRB_W-1:0]   m_wstrb;
    logic [DATA_W-1:0]   if_rdata;
    logic [DATA_W-1:0]   dm_rdata;
    logic                m_req;
    logic                if_ack;
    logic                dm_ack;
    logic                any_req;
    logic                grant_dm;
    logic                unused_if_fields;

    assign any_req  = if_bus.req | dm_bus.req;
    assign grant_dm = dm_bus.req & ~(if_bus.req & (starve_cnt == CNT_MAX));

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: state_nxt is defaulted first so no path through the case leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = WAIT;
            WAIT:    if (m_bus.ack) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        m_req  = (state == WAIT);
        busy   = (state != IDLE);
        if_ack = (state == RESP) & ~owner;
        dm_ack = (state == RESP) & owner;
    end

    // NOTE: the data registers are reset too, since their zero values are visible on the ports right after reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            owner      <= 1'b0;
            starve_cnt <= '0;
            m_we       <= 1'b0;
            m_addr     <= '0;
            m_wdata    <= '0;
            m_wstrb    <= '0;
            if_rdata   <= '0;
            dm_rdata   <= '0;
        end else begin
            if (state == IDLE && any_req) begin
                owner   <= grant_dm;
                m_we    <= grant_dm & dm_bus.we;
                m_addr  <= grant_dm ? dm_bus.addr  : if_bus.addr;
                m_wdata <= grant_dm ? dm_bus.wdata : '0;
                m_wstrb <= grant_dm ? dm_bus.wstrb : '0;
                // A DM grant with IF waiting implies the count is still below the limit.
                if (grant_dm && if_bus.req) begin
                    starve_cnt <= starve_cnt + CNT_W'(1);
                end else begin
                    starve_cnt <= '0;
                end
            end
            if (state == WAIT && m_bus.ack) begin
                if (!owner) begin
                    if_rdata <= m_bus.rdata;
                end else if (!m_we) begin
                    dm_rdata <= m_bus.rdata;
                end
            end
        end
    end

    assign m_bus.req    = m_req;
    assign m_bus.we     = m_we;
    assign m_bus.addr   = m_addr;
    assign m_bus.wdata  = m_wdata;
    assign m_bus.wstrb  = m_wstrb;
    assign if_bus.ack   = if_ack;
    assign if_bus.rdata = if_rdata;
    assign dm_bus.ack   = dm_ack;
    assign dm_bus.rdata = dm_rdata;

    assign stall_if  = if_bus.req & ~if_ack;
    assign stall_mem = dm_bus.req & ~dm_ack;

    // Fetch is read-only; its write-side bus fields carry nothing.
    assign unused_if_fields = ^{if_bus.we, if_bus.wdata, if_bus.wstrb};
endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Self-checking bench for imem_dmem_arbiter: a transaction-level reference (grant rule, shadow
// memory, expected acks/stalls) checks the DUT under directed and randomized traffic.
module tb_imem_dmem_arbiter;
    localparam int AW    = 32;
    localparam int DW    = 64;
    localparam int SW    = DW / 8;
    localparam int LIMIT = 4;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] wstrb;
    } op_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    imem_dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) if_bus ();
    imem_dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) dm_bus ();
    imem_dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m_bus ();

    logic stall_if, stall_mem, busy, owner;

    imem_dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIMIT)) dut (
        .clock     (clock),
        .reset     (reset),
        .if_bus    (if_bus),
        .dm_bus    (dm_bus),
        .m_bus     (m_bus),
        .stall_if  (stall_if),
        .stall_mem (stall_mem),
        .busy      (busy),
        .owner     (owner)
    );

    logic          mem_ack_r;
    logic          late_ack;
    logic [DW-1:0] mem_rdata;
    logic          m_ack_seen;
    assign m_bus.ack   = mem_ack_r | late_ack;
    assign m_bus.rdata = mem_rdata;
    always @(posedge clock) m_ack_seen <= m_bus.ack;

    int n_cmp = 0;
    int n_bad = 0;

    logic [DW-1:0] memarr [bit [28:0]];
    logic [DW-1:0] shadow [bit [28:0]];
    int            fixed_lat = -1;

    op_t if_q[$];
    op_t dm_q[$];
    op_t if_cur, dm_cur, inflight_op;
    bit  grant_log[$];
    int  starve = 0;
    bit  exp_owner = 1'b0;
    bit  in_flight = 1'b0;
    logic [DW-1:0] last_if = '0;
    logic [DW-1:0] last_dm = '0;

    function automatic logic [DW-1:0] init_word(input bit [28:0] idx);
        return {3'b101, idx, 16'h1234, idx[15:0]};
    endfunction

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] wd,
                                            input logic [SW-1:0] st);
        logic [DW-1:0] r = old;
        for (int b = 0; b < SW; b++) if (st[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    function automatic logic [DW-1:0] shadow_rd(input bit [28:0] idx);
        return shadow.exists(idx) ? shadow[idx] : init_word(idx);
    endfunction

    task automatic check_word(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic drive_idle();
        if_bus.req = 1'b0; if_bus.we = 1'b0; if_bus.addr = '0; if_bus.wdata = '0; if_bus.wstrb = '0;
        dm_bus.req = 1'b0; dm_bus.we = 1'b0; dm_bus.addr = '0; dm_bus.wdata = '0; dm_bus.wstrb = '0;
    endtask

    function automatic op_t rand_if_op();
        op_t o;
        o.we = 1'b0; o.addr = 32'($urandom_range(15)) << 3; o.wdata = '0; o.wstrb = '0;
        return o;
    endfunction

    function automatic op_t rand_dm_op();
        op_t o;
        o.we = 1'($urandom_range(1)); o.addr = 32'($urandom_range(15)) << 3;
        o.wdata = {$urandom, $urandom}; o.wstrb = 8'($urandom);
        return o;
    endfunction

    // Memory model: acks a request after a random or fixed number of wait cycles.
    initial begin
        int            wcnt;
        int            cur_lat;
        bit            started;
        bit [28:0]     idx;
        logic [DW-1:0] old;
        mem_ack_r = 1'b0; mem_rdata = '0; wcnt = 0; cur_lat = 0; started = 1'b0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                mem_ack_r = 1'b0; wcnt = 0; started = 1'b0;
            end else if (mem_ack_r) begin
                mem_ack_r = 1'b0;
            end else if (m_bus.req) begin
                if (!started) begin
                    started = 1'b1; wcnt = 0;
                    cur_lat = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(3));
                end
                if (wcnt == cur_lat) begin
                    idx = m_bus.addr[31:3];
                    old = memarr.exists(idx) ? memarr[idx] : init_word(idx);
                    if (m_bus.we) begin
                        memarr[idx] = merge(old, m_bus.wdata, m_bus.wstrb);
                        mem_rdata   = {$urandom, $urandom};
                    end else begin
                        mem_rdata = old;
                    end
                    mem_ack_r = 1'b1; started = 1'b0;
                end else begin
                    wcnt++;
                end
            end
        end
    end

    task automatic present(input int gap_pct);
        if (!if_bus.req && if_q.size() != 0 && int'($urandom_range(99)) >= gap_pct) begin
            if_cur = if_q.pop_front();
            if_bus.req = 1'b1; if_bus.addr = if_cur.addr;
        end
        if (!dm_bus.req && dm_q.size() != 0 && int'($urandom_range(99)) >= gap_pct) begin
            dm_cur = dm_q.pop_front();
            dm_bus.req = 1'b1; dm_bus.we = dm_cur.we; dm_bus.addr = dm_cur.addr;
            dm_bus.wdata = dm_cur.wdata; dm_bus.wstrb = dm_cur.wstrb;
        end
    endtask

    task automatic reset_model();
        starve = 0; exp_owner = 1'b0; in_flight = 1'b0; last_if = '0; last_dm = '0;
    endtask

    // Runs both requester queues to completion, checking every cycle against the reference.
    task automatic run_engine(input int max_cycles, input int gap_pct);
        int            cyc = 0;
        bit            prev_mreq;
        bit            win_dm;
        bit            e_if_ack, e_dm_ack;
        bit [28:0]     idx;
        op_t           g;
        prev_mreq = m_bus.req;
        present(gap_pct);
        while ((if_q.size() != 0 || dm_q.size() != 0 || if_bus.req || dm_bus.req || in_flight)
               && cyc < max_cycles) begin
            tick();
            cyc++;
            if (m_bus.req && !prev_mreq) begin
                check_bit("grant_has_req", if_bus.req | dm_bus.req, 1'b1);
                win_dm = dm_bus.req && !(if_bus.req && starve == LIMIT);
                if (win_dm) starve = if_bus.req ? ((starve < LIMIT) ? starve + 1 : LIMIT) : 0;
                else        starve = 0;
                g = win_dm ? dm_cur : if_cur;
                exp_owner = win_dm; in_flight = 1'b1; inflight_op = g;
                grant_log.push_back(win_dm);
                check_bit("owner", owner, win_dm);
                check_word("m_addr", 64'(m_bus.addr), 64'(g.addr));
                check_bit("m_we", m_bus.we, g.we);
                if (win_dm) begin
                    check_word("m_wdata", m_bus.wdata, g.wdata);
                    check_word("m_wstrb", 64'(m_bus.wstrb), 64'(g.wstrb));
                end
            end
            e_if_ack = in_flight && m_ack_seen && !exp_owner;
            e_dm_ack = in_flight && m_ack_seen && exp_owner;
            if (e_if_ack || e_dm_ack) begin
                idx = inflight_op.addr[31:3];
                if (inflight_op.we) shadow[idx] = merge(shadow_rd(idx), inflight_op.wdata, inflight_op.wstrb);
                else if (e_if_ack)  last_if = shadow_rd(idx);
                else                last_dm = shadow_rd(idx);
            end
            check_bit("if_ack", if_bus.ack, e_if_ack);
            check_bit("dm_ack", dm_bus.ack, e_dm_ack);
            check_bit("m_req", m_bus.req, in_flight && !(e_if_ack || e_dm_ack));
            check_bit("busy", busy, in_flight);
            check_bit("stall_if", stall_if, if_bus.req && !e_if_ack);
            check_bit("stall_mem", stall_mem, dm_bus.req && !e_dm_ack);
            check_word("if_rdata", if_bus.rdata, last_if);
            check_word("dm_rdata", dm_bus.rdata, last_dm);
            if (e_if_ack || e_dm_ack) in_flight = 1'b0;
            prev_mreq = m_bus.req;
            if (e_if_ack) if_bus.req = 1'b0;
            if (e_dm_ack) dm_bus.req = 1'b0;
            present(gap_pct);
        end
        check_bit("engine_timeout", cyc < max_cycles, 1'b1);
    endtask

    initial begin
        bit  pat [10];
        op_t o;
        int  k;
        late_ack = 1'b0;
        drive_idle();

        // Reset held with random inputs: all registered outputs stay at zero.
        for (int i = 0; i < 5; i++) begin
            if_bus.req = 1'($urandom); if_bus.addr = $urandom;
            dm_bus.req = 1'($urandom); dm_bus.we = 1'($urandom); dm_bus.addr = $urandom;
            dm_bus.wdata = {$urandom, $urandom}; dm_bus.wstrb = 8'($urandom);
            late_ack = 1'($urandom);
            tick();
            check_bit("rst_m_req", m_bus.req, 1'b0);
            check_bit("rst_m_we", m_bus.we, 1'b0);
            check_word("rst_m_addr", 64'(m_bus.addr), '0);
            check_word("rst_m_wdata", m_bus.wdata, '0);
            check_word("rst_m_wstrb", 64'(m_bus.wstrb), '0);
            check_bit("rst_if_ack", if_bus.ack, 1'b0);
            check_bit("rst_dm_ack", dm_bus.ack, 1'b0);
            check_word("rst_if_rdata", if_bus.rdata, '0);
            check_word("rst_dm_rdata", dm_bus.rdata, '0);
            check_bit("rst_busy", busy, 1'b0);
            check_bit("rst_owner", owner, 1'b0);
            check_bit("rst_stall_if", stall_if, if_bus.req);
            check_bit("rst_stall_mem", stall_mem, dm_bus.req);
        end
        drive_idle();
        late_ack = 1'b0;
        tick();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_bit("idle_busy", busy, 1'b0);
            check_bit("idle_m_req", m_bus.req, 1'b0);
        end

        // Single IF read with a two-cycle memory wait.
        memarr[29'd2] = 64'h00000013_00500093;
        shadow[29'd2] = 64'h00000013_00500093;
        fixed_lat = 2;
        o = '{we: 1'b0, addr: 32'h10, wdata: '0, wstrb: '0};
        if_q.push_back(o);
        run_engine(100, 0);
        check_word("if_read_data", if_bus.rdata, 64'h00000013_00500093);

        // Simultaneous IF and DM load: DM first, then IF.
        fixed_lat = 0;
        grant_log.delete();
        o = '{we: 1'b0, addr: 32'h20, wdata: '0, wstrb: '0};
        if_q.push_back(o);
        o = '{we: 1'b0, addr: 32'h100, wdata: 64'h5555, wstrb: 8'h0F};
        dm_q.push_back(o);
        run_engine(100, 0);
        check_word("simul_grants", 64'(grant_log.size()), 64'd2);
        if (grant_log.size() == 2) begin
            check_bit("simul_first_dm", grant_log[0], 1'b1);
            check_bit("simul_second_if", grant_log[1], 1'b0);
        end

        // Full-width store leaves dm_rdata unchanged and lands in memory.
        fixed_lat = 1;
        o = '{we: 1'b1, addr: 32'h40, wdata: 64'hDEADBEEF_00000001, wstrb: 8'hFF};
        dm_q.push_back(o);
        run_engine(100, 0);
        check_word("store_in_mem", memarr[29'd8], 64'hDEADBEEF_00000001);

        // Both requesters saturated: IF forced in after every LIMIT DM grants.
        fixed_lat = 0;
        grant_log.delete();
        for (int i = 0; i < 6; i++) if_q.push_back(rand_if_op());
        for (int i = 0; i < 10; i++) dm_q.push_back(rand_dm_op());
        run_engine(500, 0);
        pat = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        check_word("starve_grants", 64'(grant_log.size()), 64'd16);
        for (int i = 0; i < 10; i++) begin
            if (i < grant_log.size()) check_bit($sformatf("starve_order_%0d", i), grant_log[i], pat[i]);
        end

        // Random traffic with random gaps and memory latency.
        fixed_lat = -1;
        for (int i = 0; i < 30; i++) begin
            if_q.push_back(rand_if_op());
            dm_q.push_back(rand_dm_op());
        end
        run_engine(3000, 30);

        // Reset dropped while the memory request is outstanding.
        fixed_lat = 3;
        dm_bus.req = 1'b1; dm_bus.we = 1'b0; dm_bus.addr = 32'h48;
        k = 0;
        while (!m_bus.req && k < 10) begin
            tick();
            k++;
        end
        check_bit("rstw_reached_wait", m_bus.req, 1'b1);
        #1 reset = 1'b0;
        #1;
        check_bit("rstw_m_req_async", m_bus.req, 1'b0);
        check_bit("rstw_busy_async", busy, 1'b0);
        drive_idle();
        reset_model();
        tick();
        tick();
        reset = 1'b1;
        late_ack = 1'b1;
        tick();
        late_ack = 1'b0;
        check_bit("late_ack_busy", busy, 1'b0);
        check_bit("late_ack_if_ack", if_bus.ack, 1'b0);
        check_bit("late_ack_dm_ack", dm_bus.ack, 1'b0);
        tick();
        check_bit("late_ack_busy2", busy, 1'b0);
        check_bit("late_ack_dm_ack2", dm_bus.ack, 1'b0);
        check_word("rstw_dm_rdata", dm_bus.rdata, '0);
        check_bit("rstw_owner", owner, 1'b0);

        fixed_lat = -1;
        if_q.push_back(rand_if_op());
        dm_q.push_back(rand_dm_op());
        run_engine(100, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/imem_dmem_arbiter.md
Name: imem_dmem_arbiter

Overview:
Shares one single-ported unified memory between the pipelined datapath's instruction-fetch (IF) port and its data-memory (MEM stage) port. It serialises requests, drives the memory-side handshake, returns read data to the winning requester and raises per-stage stall signals so the pipeline freezes while its access is pending. It sits between the datapath and the memory model. Arbitration is DM-priority with an IF anti-starvation guard.

Parameters:
ADDR_W, 32, byte address width
DATA_W, 64, data width (doubleword memory, address >> 3 indexing inside memory)
STARVE_LIMIT, 4, consecutive DM grants allowed while if_req is pending before IF is forced (legal range >= 1)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
if_req  in  1  IF read request; held until if_ack
if_addr  in  ADDR_W  fetch address
if_ack  out  1  one-cycle completion pulse for IF
if_rdata  out  DATA_W  fetched data; valid with if_ack, held until the next IF completion
dm_req  in  1  MEM-stage request; held until dm_ack
dm_we  in  1  1 = store, 0 = load
dm_addr  in  ADDR_W  data address
dm_wdata  in  DATA_W  store data
dm_wstrb  in  DATA_W/8  byte enables for store
dm_ack  out  1  one-cycle completion pulse for DM
dm_rdata  out  DATA_W  load data; updated only on load completion
m_req  out  1  memory request, level
m_we  out  1  memory write enable
m_addr  out  ADDR_W  memory address
m_wdata  out  DATA_W  memory write data
m_wstrb  out  DATA_W/8  memory byte enables
m_ack  in  1  memory completion, one cycle; m_rdata valid on reads
m_rdata  in  DATA_W  memory read data
stall_if  out  1  if_req & ~if_ack
stall_mem  out  1  dm_req & ~dm_ack
busy  out  1  state != IDLE
owner  out  1  current/last grant: 0 = IF, 1 = DM

Behaviour:
- Reset (reset=0, async): state IDLE; m_req, m_we, if_ack, dm_ack, owner and starve count = 0; m_addr, m_wdata, m_wstrb, if_rdata, dm_rdata = 0. Any in-flight memory transaction is abandoned.
- FSM states: IDLE, WAIT, RESP.
- IDLE: if either request is high, pick the winner and register its addr/we/wdata/wstrb into m_* and set owner. Next state WAIT. Otherwise remain in IDLE.
- Winner selection: DM wins if dm_req is high, unless if_req is high and starve count == STARVE_LIMIT, in which case IF wins. With only one request high, that requester wins.
- Starve count: increments on a DM grant while if_req=1, saturating at STARVE_LIMIT. It clears on any IF grant, and on a DM grant while if_req=0.
- WAIT: m_req=1, and m_* hold stable. m_ack is legal from the first WAIT cycle. On m_ack, capture m_rdata into if_rdata (owner=0) or into dm_rdata (owner=1 and m_we=0). Next state RESP, and m_req drops the same edge.
- RESP: exactly one of if_ack/dm_ack is 1, selected by owner. Store completions pulse dm_ack and leave dm_rdata unchanged. Next state IDLE.
- Minimum latency: request seen in IDLE at cycle t, m_req high at t+1, m_ack at t+1, ack at t+2. Back-to-back throughput is one access per 3 cycles with a zero-wait memory.
- Requester may present a new request in its ack cycle. It is arbitrated in the following IDLE cycle.
- Request withdrawn during WAIT (e.g. IF flush on branch): the transaction still completes and the ack still pulses; the requester discards it.
- m_ack while not in WAIT: ignored.
- stall_if and stall_mem are combinational from the inputs and the registered acks.

Test Plan:
- Reset: hold reset=0 with random inputs -> every output 0; release -> busy=0 until a request arrives.
- IF read: if_addr=0x10, memory acks 2 cycles after m_req with 0x00000013_00500093 -> m_addr=0x10, m_we=0, if_ack pulses one cycle after m_ack with if_rdata=0x00000013_00500093, stall_if high until then.
- Simultaneous: if_req (0x20) and dm_req load (0x100) raised together -> DM served first (owner=1, m_addr=0x100), IF served next (m_addr=0x20); stall_if high across both.
- Store: dm_we=1, dm_addr=0x40, dm_wdata=0xDEADBEEF_00000001, dm_wstrb=0xFF -> m_we=1, m_wdata/m_wstrb match, dm_ack pulses, dm_rdata unchanged from prior value.
- Starvation, STARVE_LIMIT=4: dm_req and if_req held continuously -> grant order DM, DM, DM, DM, IF, DM...; starve count returns to 0 after the IF grant.
- Reset mid-WAIT: drop reset while m_req=1 -> m_req=0 immediately, state IDLE; a late m_ack after release is ignored; the next request is serviced normally.
